// File: rtl/cc_reg_pkg.sv
// rtl/cc_reg_pkg.sv - register mode encodings and byte-merge helper shared by the register bank
package cc_reg_pkg;

  // Widest mask the mode-resolution function accepts; callers zero-extend.
  localparam int MAX_REGS = 1024;

  typedef enum logic [1:0] {
    REG_MODE_RW     = 2'd0,
    REG_MODE_SHADOW = 2'd1,
    REG_MODE_RO     = 2'd2,
    REG_MODE_W1C    = 2'd3
  } reg_mode_e;

  // Conflicting masks resolve as RO > W1C > SHADOW.
  function automatic reg_mode_e reg_mode(input int i,
                                         input logic [MAX_REGS-1:0] shadow_mask,
                                         input logic [MAX_REGS-1:0] ro_mask,
                                         input logic [MAX_REGS-1:0] w1c_mask);
    if (ro_mask[i])          return REG_MODE_RO;
    else if (w1c_mask[i])    return REG_MODE_W1C;
    else if (shadow_mask[i]) return REG_MODE_SHADOW;
    else                     return REG_MODE_RW;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cc_reg_cell.sv
// rtl/cc_reg_cell.sv - one control register: RW, shadowed, read-only mirror or write-1-to-clear
module cc_reg_cell
  import cc_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter reg_mode_e             MODE        = REG_MODE_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    commit,
  input  logic [DATA_WIDTH-1:0]   status_in,
  input  logic [DATA_WIDTH-1:0]   status_set,
  output logic [DATA_WIDTH-1:0]   value
);

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] merged_active;
  logic [DATA_WIDTH-1:0] merged_shadow;
  logic [DATA_WIDTH-1:0] be_bits;
  logic [DATA_WIDTH-1:0] clr_bits;

  assign merged_active = DATA_WIDTH'(byte_merge(32'(value), 32'(wr_data), 4'(be)));
  assign merged_shadow = DATA_WIDTH'(byte_merge(32'(shadow), 32'(wr_data), 4'(be)));
  // Merging all-ones into zero yields the per-bit byte-enable mask.
  assign be_bits       = DATA_WIDTH'(byte_merge(32'd0, 32'hFFFF_FFFF, 4'(be)));
  assign clr_bits      = wr_en ? (wr_data & be_bits) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value  <= RESET_VALUE;
      shadow <= RESET_VALUE;
    end else begin
      case (MODE)
        REG_MODE_RW: begin
          if (wr_en) value <= merged_active;
        end
        REG_MODE_SHADOW: begin
          if (wr_en) shadow <= merged_shadow;
          if (wr_en && commit) value <= merged_shadow;
          else if (commit)     value <= shadow;
        end
        REG_MODE_RO: begin
          value <= status_in;
        end
        default: begin
          // Set is ORed after the clear so a simultaneous set wins.
          value <= (value & ~clr_bits) | status_set;
        end
      endcase
    end
  end

endmodule

// File: rtl/shadow_register_bank.sv
// rtl/shadow_register_bank.sv - control register bank with frame-synchronised shadow commit
module shadow_register_bank
  import cc_reg_pkg::*;
#(
  parameter int                             ADDR_WIDTH  = 6,
  parameter int                             DATA_WIDTH  = 16,
  parameter int                             NUM_REGS    = 64,
  parameter logic [NUM_REGS-1:0]            SHADOW_MASK = '0,
  parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           rd,
  input  logic                           wr,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  input  logic                           commit,
  output logic                           commit_pending,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] values_out
);

  logic                  rd_cycle;
  logic                  wr_cycle;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0]   shadow_sel;
  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_mux;

  // A simultaneous read and write is treated as a read only.
  assign rd_cycle = en & rd;
  assign wr_cycle = en & wr & ~rd;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam reg_mode_e MODE = reg_mode(i, MAX_REGS'(SHADOW_MASK), MAX_REGS'(RO_MASK),
                                          MAX_REGS'(W1C_MASK));
    localparam int HITS = int'(SHADOW_MASK[i]) + int'(RO_MASK[i]) + int'(W1C_MASK[i]);

    if (HITS > 1) begin : g_conflict
      $warning("shadow_register_bank: reg %0d has conflicting mode masks; RO > W1C > SHADOW applies", i);
    end

    assign wr_sel[i]     = wr_cycle && (addr == ADDR_WIDTH'(i));
    assign shadow_sel[i] = wr_sel[i] && (MODE == REG_MODE_SHADOW);

    cc_reg_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .MODE        (MODE),
      .RESET_VALUE (RESET_VALUE[DATA_WIDTH*i +: DATA_WIDTH])
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_sel[i]),
      .be         (be),
      .wr_data    (wr_data),
      .commit     (commit),
      .status_in  (status_in[DATA_WIDTH*i +: DATA_WIDTH]),
      .status_set (status_set[DATA_WIDTH*i +: DATA_WIDTH]),
      .value      (values_out[DATA_WIDTH*i +: DATA_WIDTH])
    );

    // RO reads bypass the registered mirror so they see the live status.
    assign rd_src[i] = (MODE == REG_MODE_RO) ? status_in[DATA_WIDTH*i +: DATA_WIDTH]
                                             : values_out[DATA_WIDTH*i +: DATA_WIDTH];
  end

  // Unmatched addresses (>= NUM_REGS) fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) rd_mux = rd_src[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      rd_valid <= rd_cycle;
      if (rd_cycle) rd_data <= rd_mux;
      if (commit)           commit_pending <= 1'b0;
      else if (|shadow_sel) commit_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shadow_register_bank.sv
// tb/tb_shadow_register_bank.sv - vector table and read scoreboard for shadow_register_bank
module tb_shadow_register_bank;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam logic [NR-1:0]    SH_M  = 16'h0020;
  localparam logic [NR-1:0]    RO_M  = 16'h0200;
  localparam logic [NR-1:0]    W1C_M = 16'h0080;
  localparam logic [NR*DW-1:0] RV    = (256'hA5A5 << 48) | (256'h0011 << 80);

  logic            clk = 1'b0;
  logic            reset, en, rd, wr, commit, rd_valid, commit_pending;
  logic [1:0]      be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wr_data, rd_data;
  logic [NR*DW-1:0] status_in, status_set, values_out;

  always #5 clk = ~clk;

  shadow_register_bank #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
    .SHADOW_MASK (SH_M), .RO_MASK (RO_M), .W1C_MASK (W1C_M), .RESET_VALUE (RV)
  ) dut (
    .clk (clk), .reset (reset), .en (en), .rd (rd), .wr (wr), .be (be), .addr (addr),
    .wr_data (wr_data), .rd_data (rd_data), .rd_valid (rd_valid), .commit (commit),
    .commit_pending (commit_pending), .status_in (status_in), .status_set (status_set),
    .values_out (values_out)
  );

  typedef struct {
    logic          rd, wr, cmt;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] wd, set7, st9;
    int            creg;
    logic [DW-1:0] cval;
    logic          cpend;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            nvec = 0;
  int            nmis = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic c, input logic [AW-1:0] a,
                              input logic [1:0] b, input logic [DW-1:0] d, input logic [DW-1:0] s7,
                              input logic [DW-1:0] s9, input int cr, input logic [DW-1:0] cv,
                              input logic cp, input logic [DW-1:0] er);
    vec_t v;
    v.rd = r; v.wr = w; v.cmt = c; v.addr = a; v.be = b; v.wd = d; v.set7 = s7; v.st9 = s9;
    v.creg = cr; v.cval = cv; v.cpend = cp; v.erd = er;
    return v;
  endfunction

  function automatic logic [DW-1:0] val(input int r);
    return values_out[DW*r +: DW];
  endfunction

  task automatic apply(input int idx, input vec_t v);
    en = v.rd | v.wr; rd = v.rd; wr = v.wr; commit = v.cmt;
    addr = v.addr; be = v.be; wr_data = v.wd;
    status_set = '0; status_set[DW*7 +: DW] = v.set7;
    status_in  = '0; status_in[DW*9 +: DW]  = v.st9;
    if (v.rd) exp_q.push_back(v.erd);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_rd_valid", idx), 16'(rd_valid), 16'(v.rd));
    check($sformatf("v%0d_reg%0d", idx, v.creg), val(v.creg), v.cval);
    check($sformatf("v%0d_pending", idx), 16'(commit_pending), 16'(v.cpend));
  endtask

  // Read scoreboard: every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", rd_data, 16'hXXXX);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b0; en = 0; rd = 0; wr = 0; commit = 0; be = 0; addr = 0; wr_data = 0;
    status_set = '0; status_in = '0; status_in[DW*9 +: DW] = 16'hBEEF;
    repeat (2) @(negedge clk);
    check("rst_reg3", val(3), 16'hA5A5);
    check("rst_reg5", val(5), 16'h0011);
    check("rst_reg9", val(9), 16'h0000);
    check("rst_rd_valid", 16'(rd_valid), 16'h0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_pending", 16'(commit_pending), 16'h0);
    reset = 1'b1;

    //                rd wr cmt addr be     wd        set7      st9       reg val       pend erd
    vecs.push_back(mk(1, 0, 0, 3,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 3, 16'hA5A5, 0, 16'hA5A5));
    vecs.push_back(mk(0, 1, 0, 0,  2'b10, 16'h1234, 16'h0000, 16'hBEEF, 0, 16'h1200, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0,  2'b01, 16'hFF77, 16'h0000, 16'hBEEF, 0, 16'h1277, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 0,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'h1277, 0, 16'h1277));
    vecs.push_back(mk(0, 1, 0, 5,  2'b11, 16'h00BE, 16'h0000, 16'hBEEF, 5, 16'h0011, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 5,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 5, 16'h0011, 1, 16'h0011));
    vecs.push_back(mk(0, 0, 1, 0,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 5, 16'h00BE, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 5,  2'b11, 16'hCAFE, 16'h0000, 16'hBEEF, 5, 16'hCAFE, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 5,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 5, 16'hCAFE, 0, 16'hCAFE));
    vecs.push_back(mk(0, 1, 0, 5,  2'b01, 16'h1234, 16'h0000, 16'hBEEF, 5, 16'hCAFE, 1, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 5,  2'b11, 16'h1111, 16'h0000, 16'hBEEF, 5, 16'hCAFE, 1, 16'hCAFE));
    vecs.push_back(mk(0, 0, 1, 0,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 5, 16'hCA34, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0,  2'b00, 16'h0000, 16'h0004, 16'hBEEF, 7, 16'h0004, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 7,  2'b00, 16'h0000, 16'h0000, 16'hBEEF, 7, 16'h0004, 0, 16'h0004));
    vecs.push_back(mk(0, 1, 0, 7,  2'b11, 16'h0004, 16'h0004, 16'hBEEF, 7, 16'h0004, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 7,  2'b11, 16'h0004, 16'h0000, 16'hBEEF, 7, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0,  2'b00, 16'h0000, 16'h0103, 16'hBEEF, 7, 16'h0103, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 7,  2'b01, 16'hFFFF, 16'h0000, 16'hBEEF, 7, 16'h0100, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 9,  2'b11, 16'h0000, 16'h0000, 16'hBEEF, 9, 16'hBEEF, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 9,  2'b00, 16'h0000, 16'h0000, 16'h1357, 9, 16'h1357, 0, 16'h1357));
    vecs.push_back(mk(1, 0, 0, 16, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 9, 16'hBEEF, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 63, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'h1277, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16, 2'b11, 16'hFFFF, 16'h0000, 16'hBEEF, 0, 16'h1277, 0, 16'h0000));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Async reset lands between a read strobe and its result edge.
    apply(100, mk(0, 1, 0, 5, 2'b11, 16'h7777, 16'h0000, 16'hBEEF, 5, 16'hCA34, 1, 16'h0000));
    en = 1; rd = 1; wr = 0; addr = 0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_reg0", val(0), 16'h0000);
    check("mid_rst_reg5", val(5), 16'h0011);
    check("mid_rst_reg7", val(7), 16'h0000);
    check("mid_rst_pending", 16'(commit_pending), 16'h0);
    @(negedge clk);
    check("mid_rst_rd_valid", 16'(rd_valid), 16'h0);
    en = 0; rd = 0;
    reset = 1'b1;
    apply(101, mk(1, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'h0000, 0, 16'h0000));
    apply(102, mk(1, 0, 0, 3, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 3, 16'hA5A5, 0, 16'hA5A5));
    apply(103, mk(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'hBEEF, 5, 16'h0011, 0, 16'h0000));
    check("reads_drained", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
